// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared encodings for the multicycle RV32I control unit.
package rv_ctrl_pkg;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [3:0] {
        CLS_NONE, CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR
    } cls_t;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_4    = 2'b10;
    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;
    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_ILL  = 2'b01;
    localparam logic [1:0] CAUSE_BUS  = 2'b10;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction fields, memory handshake and datapath controls.
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_ready;
    logic       trap_ack;
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] wb_sel;
    logic       trap;
    logic [1:0] trap_cause;
    modport master (
        input  opcode, funct3, mem_ready, trap_ack,
        output mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write,
               alu_op, alu_src_a, alu_src_b, wb_sel, trap, trap_cause
    );
    modport slave (
        output opcode, funct3, mem_ready, trap_ack,
        input  mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write,
               alu_op, alu_src_a, alu_src_b, wb_sel, trap, trap_cause
    );
endinterface

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: maps an opcode to its instruction class and flags unknown opcodes.
module ctrl_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output cls_t       o_cls,
    output logic       o_illegal
);
    always_comb begin
        o_cls = CLS_NONE;
        case (i_opcode)
            OP_R:      o_cls = CLS_R;
            OP_I:      o_cls = CLS_I;
            OP_LOAD:   o_cls = CLS_LOAD;
            OP_STORE:  o_cls = CLS_STORE;
            OP_BRANCH: o_cls = CLS_BRANCH;
            OP_LUI:    o_cls = CLS_LUI;
            OP_AUIPC:  o_cls = CLS_AUIPC;
            OP_JAL:    o_cls = CLS_JAL;
            OP_JALR:   o_cls = CLS_JALR;
            default:   o_cls = CLS_NONE;
        endcase
        o_illegal = o_cls == CLS_NONE;
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer with memory-wait timeout.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int XLEN    = 32
) (
    input logic clk,
    input logic rstn,
    multicycle_ctrl_if.master io_bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    generate
        if (TIMEOUT < 1 || TIMEOUT > 255 || (XLEN != 32 && XLEN != 64)) begin : g_bad_param
            $error("multicycle_ctrl: illegal TIMEOUT or XLEN");
        end
    endgenerate
    state_t          r_state, w_next;
    cls_t            r_cls, w_cls;
    logic            w_illegal, w_busy, w_tout;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_cause;
    ctrl_decoder u_dec (.i_opcode(io_bus.opcode), .o_cls(w_cls), .o_illegal(w_illegal));
    assign w_busy = r_state == S_FETCH || r_state == S_MEM;
    assign w_tout = w_busy && !io_bus.mem_ready && r_cnt == CW'(TIMEOUT);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_FETCH;
            r_cls   <= CLS_NONE;
            r_cnt   <= '0;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_cls <= w_cls;
            r_cnt <= (w_next != r_state) ? '0 : (w_busy && !io_bus.mem_ready) ? r_cnt + 1'b1 : r_cnt;
            if (r_state == S_DECODE && w_illegal) r_cause <= CAUSE_ILL;
            else if (w_tout) r_cause <= CAUSE_BUS;
            else if (r_state == S_TRAP && io_bus.trap_ack) r_cause <= CAUSE_NONE;
        end
    end
    // Outputs are gated by rstn so the FETCH request stays low while reset is held.
    always_comb begin
        w_next               = r_state;
        io_bus.mem_req       = 1'b0;
        io_bus.mem_we        = 1'b0;
        io_bus.ir_write      = 1'b0;
        io_bus.pc_write      = 1'b0;
        io_bus.pc_write_cond = 1'b0;
        io_bus.reg_write     = 1'b0;
        io_bus.alu_op        = ALU_ADD;
        io_bus.alu_src_a     = 1'b0;
        io_bus.alu_src_b     = SRCB_RS2;
        io_bus.wb_sel        = WB_ALU;
        io_bus.trap          = rstn && r_state == S_TRAP;
        io_bus.trap_cause    = r_cause;
        if (rstn) begin
            case (r_state)
                S_FETCH: begin
                    io_bus.mem_req   = 1'b1;
                    io_bus.alu_src_a = 1'b1;
                    io_bus.alu_src_b = SRCB_4;
                    io_bus.ir_write  = io_bus.mem_ready;
                    io_bus.pc_write  = io_bus.mem_ready;
                    w_next = io_bus.mem_ready ? S_DECODE : w_tout ? S_TRAP : S_FETCH;
                end
                S_DECODE: w_next = w_illegal ? S_TRAP : S_EXEC;
                S_EXEC: begin
                    io_bus.alu_op = (r_cls == CLS_R || r_cls == CLS_I) ? ALU_FUNCT :
                                    r_cls == CLS_BRANCH ? ALU_BR : r_cls == CLS_LUI ? ALU_PASSB : ALU_ADD;
                    io_bus.alu_src_a     = r_cls == CLS_AUIPC || r_cls == CLS_JAL;
                    io_bus.alu_src_b     = (r_cls == CLS_R || r_cls == CLS_BRANCH) ? SRCB_RS2 : SRCB_IMM;
                    io_bus.pc_write_cond = r_cls == CLS_BRANCH;
                    io_bus.pc_write      = r_cls == CLS_JAL || r_cls == CLS_JALR;
                    w_next = (r_cls == CLS_LOAD || r_cls == CLS_STORE) ? S_MEM :
                             r_cls == CLS_BRANCH ? S_FETCH : S_WB;
                end
                S_MEM: begin
                    io_bus.mem_req = 1'b1;
                    io_bus.mem_we  = r_cls == CLS_STORE;
                    w_next = io_bus.mem_ready ? (r_cls == CLS_STORE ? S_FETCH : S_WB) :
                             w_tout ? S_TRAP : S_MEM;
                end
                S_WB: begin
                    io_bus.reg_write = 1'b1;
                    io_bus.wb_sel = r_cls == CLS_LOAD ? WB_MEM :
                                    (r_cls == CLS_JAL || r_cls == CLS_JALR) ? WB_PC4 : WB_ALU;
                    w_next = S_FETCH;
                end
                S_TRAP: w_next = io_bus.trap_ack ? S_FETCH : S_TRAP;
                default: w_next = S_FETCH;
            endcase
        end
    end
endmodule
